// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: turns the camera byte stream into RGB565 frame buffer writes.
// Runs entirely in the camera pclk domain. Registers vsync, href and the data bus once,
// pairs bytes into pixels, decimates by DECIM in both axes, and writes a W x H buffer.
// It reports frame_start, frame_done, busy, a sticky overrun flag and a captured-frame count.
// Optional feature macro: CAM_CAPTURE_FRAME_SKIP_EN. When it is defined, SKIP camera frames
// are dropped after every captured frame.
module cam_capture_ctrl #(
    parameter int CAM_W = 640,
    parameter int CAM_H = 480,
    parameter int W     = 320,
    parameter int H     = 240,
    parameter int DECIM = 2,
    parameter int SKIP  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  cam_data,
    output logic        we,
    output logic [16:0] wAddr,
    output logic [15:0] wData,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  frame_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_VS = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [16:0] FB_SIZE = 17'(W * H);
    localparam logic [16:0] ROW_INC = 17'(W);

    logic [1:0]  state_q, state_d;
    logic        vsync_q, vsync_prev_q, href_q, href_prev_q;
    logic [7:0]  data_q, hi_q;
    logic        phase_q;
    logic [15:0] x_q, y_q;
    logic [16:0] addr_q, row_base_q, waddr_q;
    logic [15:0] wdata_q;
    logic        we_q, frame_start_q, overrun_q;
    logic [7:0]  frame_cnt_q;
    logic        skip_zero;

    // Edges are taken between the registered sample and its previous value.
    logic vs_fall, vs_rise, hr_rise, hr_fall;
    assign vs_fall = vsync_prev_q & ~vsync_q;
    assign vs_rise = vsync_q & ~vsync_prev_q;
    assign hr_rise = href_q & ~href_prev_q;
    assign hr_fall = ~href_q & href_prev_q;

    // Decimation keep tests; with DECIM == 1 every pixel and line is kept.
    logic line_kept, pix_kept, in_bounds;
    assign line_kept = (DECIM == 1) ? 1'b1 : ~y_q[0];
    assign pix_kept  = line_kept & ((DECIM == 1) ? 1'b1 : ~x_q[0]);
    assign in_bounds = (addr_q < FB_SIZE) && (x_q < 16'(CAM_W)) && (y_q < 16'(CAM_H));

`ifdef CAM_CAPTURE_FRAME_SKIP_EN
    logic [7:0] skip_q;
    assign skip_zero = (skip_q == 8'd0);

    // Skip counter: loaded after each captured frame, consumed by ignored vsync falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_q <= 8'd0;
        end else if (state_q == DONE) begin
            skip_q <= 8'(SKIP);
        end else if (state_q == WAIT_VS && enable && vs_fall && !skip_zero) begin
            skip_q <= skip_q - 8'd1;
        end
    end
`else
    assign skip_zero = 1'b1;
`endif

    // Next-state logic for the capture sequencer.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && vsync_q) state_d = WAIT_VS;
            WAIT_VS: begin
                if (!enable)                    state_d = IDLE;
                else if (vs_fall && skip_zero)  state_d = ACTIVE;
            end
            ACTIVE:  if (vs_rise) state_d = DONE;
            DONE:    state_d = enable ? WAIT_VS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Input sampling, state register and the pixel/address datapath.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every read sees last cycle's value.
        if (reset) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b0;
            vsync_prev_q  <= 1'b0;
            href_q        <= 1'b0;
            href_prev_q   <= 1'b0;
            data_q        <= 8'd0;
            hi_q          <= 8'd0;
            phase_q       <= 1'b0;
            x_q           <= 16'd0;
            y_q           <= 16'd0;
            addr_q        <= 17'd0;
            row_base_q    <= 17'd0;
            waddr_q       <= 17'd0;
            wdata_q       <= 16'd0;
            we_q          <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            vsync_q       <= vsync;
            vsync_prev_q  <= vsync_q;
            href_q        <= href;
            href_prev_q   <= href_q;
            data_q        <= cam_data;
            state_q       <= state_d;
            we_q          <= 1'b0;
            frame_start_q <= 1'b0;

            if (state_q == WAIT_VS && state_d == ACTIVE) begin
                frame_start_q <= 1'b1;
                phase_q       <= 1'b0;
                x_q           <= 16'd0;
                y_q           <= 16'd0;
                addr_q        <= 17'd0;
                row_base_q    <= 17'd0;
            end

            if (state_q == ACTIVE) begin
                if (hr_rise) begin
                    // The first byte of a line is always a high byte.
                    hi_q    <= data_q;
                    phase_q <= 1'b1;
                    x_q     <= 16'd0;
                    if (line_kept) addr_q <= row_base_q;
                end else if (href_q) begin
                    if (!phase_q) begin
                        hi_q    <= data_q;
                        phase_q <= 1'b1;
                    end else begin
                        phase_q <= 1'b0;
                        x_q     <= x_q + 16'd1;
                        if (pix_kept) begin
                            if (in_bounds) begin
                                we_q    <= 1'b1;
                                waddr_q <= addr_q;
                                wdata_q <= {hi_q, data_q};
                                addr_q  <= addr_q + 17'd1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                end else if (hr_fall) begin
                    // Line end: an unpaired trailing byte is dropped by clearing the phase.
                    y_q     <= y_q + 16'd1;
                    phase_q <= 1'b0;
                    if (line_kept && row_base_q < FB_SIZE) row_base_q <= row_base_q + ROW_INC;
                end
            end

            if (state_q == DONE) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign we          = we_q;
    assign wAddr       = waddr_q;
    assign wData       = wdata_q;
    assign frame_start = frame_start_q;
    assign frame_done  = (state_q == DONE);
    assign busy        = (state_q == ACTIVE);
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences camera pixel writes into the 320x240 RGB565 frame buffer and its 3x3 zone colour detector.
- Runs in the camera pclk domain. Samples vsync, href and the 8-bit camera data bus, and pairs bytes into RGB565 pixels.
- Decimates the 640x480 camera stream to 320x240, then generates we, wAddr, wData and the one-cycle frame_start pulse that clears the zone accumulators.
- Also reports frame completion and overrun status to the turret control logic.

Parameters:
- CAM_W, 640, camera pixels per active line.
- CAM_H, 480, camera active lines per frame.
- W, 320, frame buffer width in pixels.
- H, 240, frame buffer height in pixels.
- DECIM, 2, keep 1 of every DECIM pixels and 1 of every DECIM lines; legal values are 1 and 2.
- SKIP, 1, frames dropped between captured frames; used only with FRAME_SKIP_EN.

Ports:
- clk  in  1  camera pclk; sole clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture enable; sampled only at frame boundaries.
- vsync  in  1  camera vsync; high = vertical blanking.
- href  in  1  camera href; high = active line bytes.
- cam_data  in  8  camera byte bus.
- we  out  1  frame buffer write strobe.
- wAddr  out  17  frame buffer write address, 0..W*H-1.
- wData  out  16  RGB565 pixel, {first byte, second byte}.
- frame_start  out  1  one-cycle pulse at start of a captured frame.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- busy  out  1  high while in ACTIVE.
- overrun  out  1  sticky; a write beyond W*H-1 was suppressed.
- frame_cnt  out  8  captured-frame counter, wraps 255->0.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; all counters, byte phase and registered vsync/href cleared.
- Input registering: vsync and href are registered once. Edges are detected on the registered versions.
  - vsync fall = start of active frame.
  - vsync rise = end of frame.
  - href rise = line start.
  - href fall = line end.
- IDLE:
  - if enable=1 and vsync=1 (in blanking) -> WAIT_VS.
  - Else stay. Entering mid-frame never starts a capture.
- WAIT_VS:
  - on vsync fall -> ACTIVE; frame_start=1 for exactly that next cycle; clear pixel/line/address counters.
  - if enable=0 -> IDLE.
- ACTIVE:
  - Byte handling with href=1:
    - byte phase toggles each cycle; phase 0 latches the high byte.
    - phase 1 completes a pixel; pixel x counter increments.
  - A pixel is kept when x%DECIM==0 and y%DECIM==0.
    - Kept pixel: we=1 for one cycle, the cycle after the second byte is sampled (latency 1 clk from low byte). wData={hi,lo}, wAddr=current address.
    - Address increments after each write; it never wraps.
  - href rise: x=0, phase=0.
  - href fall: y increments; a pending odd byte is discarded.
  - vsync rise -> DONE.
- DONE: frame_done=1 for one cycle; frame_cnt increments.
  - then -> WAIT_VS if enable=1, else -> IDLE.
- Bounds and errors:
  - Address bound: a kept pixel with address >= W*H gives we=0 and sets overrun (cleared only by reset). Pixels with x >= CAM_W are treated identically.
  - Short line (fewer than CAM_W pixels) or short frame: no error. The next line/frame starts cleanly; the address continues from (y/DECIM)*W at each kept line start.
  - Line address: recomputed at href rise of a kept line as (y/DECIM)*W using an incremental row-base register (add W per kept line; no multiplier).
- Enable deassertion: enable falling during ACTIVE has no effect until DONE.
- Reset priority: reset mid-frame aborts immediately. There is no frame_done and we=0 from the next cycle.
- Simultaneous events: vsync rise and href fall in the same cycle means line end processed, then DONE.
- Pulse guarantee: frame_start always precedes the first we of a frame by at least 2 cycles. we is never asserted outside ACTIVE.

Optional Feature:
- Macro: CAM_CAPTURE_FRAME_SKIP_EN.
- Defined:
  - After each DONE, the next SKIP vsync-fall events are ignored: the block stays in WAIT_VS, with no frame_start and no we.
  - frame_cnt counts captured frames only.
  - The skip counter resets on reset.
- Undefined: every frame is captured; SKIP is unused.

Test Plan:
- CAM_W=8, CAM_H=4, W=4, H=2, DECIM=2; one frame with bytes 0x00..0x3F sequential:
  - frame_start once, then exactly 8 writes at addr 0..7.
  - addr0 wData=0x0001, addr1=0x0405, addr4=0x2021.
  - frame_done once, frame_cnt=1.
- enable raised mid-ACTIVE of the camera frame -> no we until the next vsync fall; then a full 8-write frame.
- Frame with 6 lines (CAM_H exceeded):
  - writes stop at addr 7; overrun=1 and stays 1 across the next frame.
  - reset clears it to 0.
- Reset asserted after 3 writes -> we=0 next cycle, no frame_done, all outputs 0; the next frame starts at addr 0.
- Short line of 5 pixels (odd trailing byte) -> 3 writes on that line; the next kept line starts at row-base W.
- CAM_CAPTURE_FRAME_SKIP_EN with SKIP=1, 4 camera frames -> frame_start on frames 1 and 3 only; frame_cnt=2.
